jtag_master_shifter: RTL and testbench

JTAG_MASTER_SHIFTER -- requirements
Module: jtag_master_shifter

---
 rtl/jtag_master_shifter.sv | 230 +++++++++++++++++++++++
 tb/tb_jtag_master_shifter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_master_shifter.sv
// +------------------------------------------------------------------------+
// | jtag_master_shifter: command-driven JTAG TAP sequencer and shifter.     |
// | Optional macro JTAG_MASTER_TRST_EN drives TRST low during TAP resets.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module jtag_master_shifter #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic [4:0]  cmd_len_i,
  input  logic [31:0] cmd_data_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        jtag_tck_o,
  output logic        jtag_tms_o,
  output logic        jtag_tdi_o,
  output logic        jtag_trst_no,
  input  logic        jtag_tdo_i
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RST_SEQ = 3'd1,
    S_HDR     = 3'd2,
    S_SHIFT   = 3'd3,
    S_TRAILER = 3'd4,
    S_RSP     = 3'd5
  } state_e;

  localparam logic [8:0] c_DIV      = 9'(CLK_DIV);
  localparam logic [8:0] c_PER_LAST = 9'(2 * CLK_DIV - 1);
`ifdef JTAG_MASTER_TRST_EN
  localparam logic       c_TRST_EN  = 1'b1;
`else
  localparam logic       c_TRST_EN  = 1'b0;
`endif

  state_e      state_q, state_d;
  logic [8:0]  phase_q, phase_d;
  logic [4:0]  bit_q, bit_d;
  logic [4:0]  len_q, len_d;
  logic [31:0] data_q, data_d;
  logic [31:0] cap_q, cap_d;
  logic        ir_q, ir_d;
  logic        auto_q, auto_d;
  logic        pre_q, pre_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        tck_q, tck_d;
  logic        tms_q, tms_d;
  logic        tdi_q, tdi_d;

  logic        w_run;
  logic        w_pend;
  logic        w_tms;
  logic        w_tdi;
  logic        w_last;
  logic        w_cmd_ready;

  assign w_cmd_ready = (state_q == S_IDLE) && !rsp_valid_q;
  assign cmd_ready_o = w_cmd_ready;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = cap_q;
  assign jtag_tck_o  = tck_q;
  assign jtag_tms_o  = tms_q;
  assign jtag_tdi_o  = tdi_q;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    bit_d       = bit_q;
    len_d       = len_q;
    data_d      = data_q;
    cap_d       = cap_q;
    ir_d        = ir_q;
    auto_d      = auto_q;
    pre_d       = pre_q;
    rsp_valid_d = rsp_valid_q;
    tck_d       = 1'b0;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    w_tms       = 1'b0;
    w_tdi       = 1'b0;
    w_last      = 1'b0;
    w_run       = state_q inside {S_RST_SEQ, S_HDR, S_SHIFT, S_TRAILER};
    w_pend      = (phase_q == c_PER_LAST);

    // TMS/TDI of the TCK period currently being generated
    case (state_q)
      S_RST_SEQ: begin
        w_tms  = (bit_q != 5'd5);
        w_last = (bit_q == 5'd5);
      end
      S_HDR: begin
        w_tms  = (bit_q == 5'd0) || (ir_q && (bit_q == 5'd1));
        w_last = (bit_q == (ir_q ? 5'd3 : 5'd2));
      end
      S_SHIFT: begin
        w_tms  = (bit_q == len_q);
        w_tdi  = data_q[bit_q];
        w_last = (bit_q == len_q);
      end
      S_TRAILER: begin
        w_tms  = (bit_q == 5'd0);
        w_last = (bit_q == 5'd1);
      end
      default: ;
    endcase

    // Pin registers lag the phase counter by one cycle, keeping TCK/TMS/TDI aligned
    if (w_run) begin
      phase_d = w_pend ? 9'd0 : phase_q + 9'd1;
      tck_d   = !pre_q && (phase_q >= c_DIV);
      if ((phase_q == 9'd0) && !pre_q) begin
        tms_d = w_tms;
        tdi_d = w_tdi;
      end
      if ((state_q == S_SHIFT) && (phase_q == c_DIV + 9'd1)) begin
        cap_d[bit_q] = jtag_tdo_i;
      end
      if (w_pend) begin
        if (pre_q) begin
          pre_d = 1'b0;
        end else if (w_last) begin
          bit_d = 5'd0;
          case (state_q)
            S_RST_SEQ: state_d = auto_q ? S_IDLE : S_RSP;
            S_HDR:     state_d = S_SHIFT;
            S_SHIFT:   state_d = S_TRAILER;
            default:   state_d = S_RSP;
          endcase
        end else begin
          bit_d = bit_q + 5'd1;
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i && w_cmd_ready) begin
          phase_d = 9'd0;
          bit_d   = 5'd0;
          len_d   = cmd_len_i;
          data_d  = cmd_data_i;
          cap_d   = 32'd0;
          auto_d  = 1'b0;
          case (cmd_op_i)
            2'b01: begin
              state_d = S_HDR;
              ir_d    = 1'b1;
            end
            2'b10: begin
              state_d = S_HDR;
              ir_d    = 1'b0;
            end
            default: begin
              state_d = S_RST_SEQ;
              pre_d   = c_TRST_EN;
            end
          endcase
        end
      end
      S_RSP: begin
        rsp_valid_d = 1'b1;
        if (rsp_valid_q && rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_RST_SEQ;
      phase_q     <= 9'd0;
      bit_q       <= 5'd0;
      len_q       <= 5'd0;
      data_q      <= 32'd0;
      cap_q       <= 32'd0;
      ir_q        <= 1'b0;
      auto_q      <= 1'b1;
      pre_q       <= c_TRST_EN;
      rsp_valid_q <= 1'b0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      len_q       <= len_d;
      data_q      <= data_d;
      cap_q       <= cap_d;
      ir_q        <= ir_d;
      auto_q      <= auto_d;
      pre_q       <= pre_d;
      rsp_valid_q <= rsp_valid_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
    end
  end

`ifdef JTAG_MASTER_TRST_EN
  logic trst_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      trst_q <= 1'b0;
    end else begin
      trst_q <= !(w_run && pre_q);
    end
  end

  assign jtag_trst_no = trst_q & ~rst_i;
`else
  assign jtag_trst_no = 1'b1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_jtag_master_shifter.sv
// +------------------------------------------------------------------------+
// | tb_jtag_master_shifter: directed bench with a behavioural TAP model.    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_jtag_master_shifter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [4:0]  cmd_len = 5'd0;
  logic [31:0] cmd_data = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        tck, tms, tdi, trst_n;
  logic        tdo = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jtag_master_shifter #(.CLK_DIV(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_op_i     (cmd_op),
    .cmd_len_i    (cmd_len),
    .cmd_data_i   (cmd_data),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_data_o   (rsp_data),
    .jtag_tck_o   (tck),
    .jtag_tms_o   (tms),
    .jtag_tdi_o   (tdi),
    .jtag_trst_no (trst_n),
    .jtag_tdo_i   (tdo)
  );

  // IEEE 1149.1 TAP: 5-bit IR capturing 0x01, 1-bit DR loopback capturing 0
  localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5,
                 PAUDR = 6, EX2DR = 7, UPDR = 8, SELIR = 9, CAPIR = 10,
                 SHIR = 11, EX1IR = 12, PAUIR = 13, EX2IR = 14, UPIR = 15;
  int         tap = TLR;
  logic [4:0] ir_sr = 5'd0;
  logic [4:0] tap_ir = 5'd0;
  logic       dr_ff = 1'b0;

  function automatic int tap_next(input int s, input logic m);
    case (s)
      TLR:   return m ? TLR   : RTI;
      RTI:   return m ? SELDR : RTI;
      SELDR: return m ? SELIR : CAPDR;
      CAPDR: return m ? EX1DR : SHDR;
      SHDR:  return m ? EX1DR : SHDR;
      EX1DR: return m ? UPDR  : PAUDR;
      PAUDR: return m ? EX2DR : PAUDR;
      EX2DR: return m ? UPDR  : SHDR;
      UPDR:  return m ? SELDR : RTI;
      SELIR: return m ? TLR   : CAPIR;
      CAPIR: return m ? EX1IR : SHIR;
      SHIR:  return m ? EX1IR : SHIR;
      EX1IR: return m ? UPIR  : PAUIR;
      PAUIR: return m ? EX2IR : PAUIR;
      EX2IR: return m ? UPIR  : SHIR;
      default: return m ? SELDR : RTI;
    endcase
  endfunction

  always @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      tap <= TLR;
    end else begin
      case (tap)
        CAPDR: dr_ff <= 1'b0;
        SHDR:  dr_ff <= tdi;
        CAPIR: ir_sr <= 5'h01;
        SHIR:  ir_sr <= {tdi, ir_sr[4:1]};
        UPIR:  tap_ir <= ir_sr;
        default: ;
      endcase
      tap <= tap_next(tap, tms);
    end
  end

  always @(negedge tck) tdo <= (tap == SHIR) ? ir_sr[0] : dr_ff;

  // Pin history: newest TCK period in bit 0
  int          tck_total = 0;
  logic [63:0] tms_hist = '0;
  logic [63:0] tdi_hist = '0;
  always @(posedge tck) begin
    tck_total <= tck_total + 1;
    tms_hist  <= {tms_hist[62:0], tms};
    tdi_hist  <= {tdi_hist[62:0], tdi};
  end

  int   cyc = 0, last_rise = 0, rise_gap = 0, hi_len = 0, rsp_rises = 0;
  logic tck_prev = 1'b0, rv_prev = 1'b0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    tck_prev <= tck;
    rv_prev <= rsp_valid;
    if (rsp_valid && !rv_prev) rsp_rises <= rsp_rises + 1;
    if (tck && !tck_prev) begin
      rise_gap  <= cyc - last_rise;
      last_rise <= cyc;
    end
    if (!tck && tck_prev) hi_len <= cyc - last_rise;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [4:0] len, input logic [31:0] data,
                      input logic keep_valid);
    int n;
    n = 0;
    cmd_op = op; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept_timeout", 64'(n < 200), 64'd1);
    @(negedge clk);
    if (keep_valid) begin
      cmd_op = 2'b10; cmd_len = 5'd3; cmd_data = 32'hFFFF_FFFF;
    end else begin
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_rsp(output logic prev_tck);
    int n;
    n = 0;
    prev_tck = tck;
    while (!rsp_valid && n < 2000) begin
      prev_tck = tck;
      @(negedge clk);
      n++;
    end
    check("rsp_timeout", 64'(n < 2000), 64'd1);
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_after_hs", 64'(rsp_valid), 64'd0);
    check("cmd_ready_after_hs", 64'(cmd_ready), 64'd1);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", 64'(n < 2000), 64'd1);
  endtask

  initial begin
    int   base;
    int   rbase;
    logic ptck;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tck", 64'(tck), 64'd0);
    check("rst_tms", 64'(tms), 64'd1);
    check("rst_tdi", 64'(tdi), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
`ifdef JTAG_MASTER_TRST_EN
    check("rst_trst", 64'(trst_n), 64'd0);
`else
    check("rst_trst", 64'(trst_n), 64'd1);
`endif

    // Autonomous TAP reset after release
    base = tck_total; rbase = rsp_rises;
    rst = 1'b0;
    wait_ready();
    check("auto_periods", 64'(tck_total - base), 64'd6);
    check("auto_tms", 64'(tms_hist[5:0]), 64'b111110);
    check("auto_tap_rti", 64'(tap), 64'(RTI));
    check("auto_no_rsp", 64'(rsp_rises - rbase), 64'd0);

    // SHIFT_IR, N=5, data 0x01
    base = tck_total;
    send(2'b01, 5'd4, 32'h0000_0001, 1'b0);
    wait_rsp(ptck);
    check("ir_prev_tck_high", 64'(ptck), 64'd1);
    check("ir_tck_low_at_rsp", 64'(tck), 64'd0);
    check("ir_periods", 64'(tck_total - base), 64'd11);
    check("ir_tms", 64'(tms_hist[10:0]), 64'b1100_00001_10);
    check("ir_tdi", 64'(tdi_hist[6:2]), 64'b10000);
    check("ir_rsp_data", 64'(rsp_data), 64'h1);
    check("ir_tap_ir", 64'(tap_ir), 64'h01);
    check("ir_tck_period", 64'(rise_gap), 64'd8);
    check("ir_tck_high_len", 64'(hi_len), 64'd4);
    finish_rsp();

    // SHIFT_DR, N=32 through the loopback flop, with a competing command held valid
    base = tck_total;
    send(2'b10, 5'd31, 32'hABBA_ABBA, 1'b1);
    wait_rsp(ptck);
    check("dr32_periods", 64'(tck_total - base), 64'd37);
    check("dr32_tms", 64'(tms_hist[36:0]), {27'd0, 3'b100, 31'd0, 1'b1, 2'b10});
    check("dr32_tdi", 64'(tdi_hist[33:2]), 64'(32'h5DD5_5DD5));
    check("dr32_rsp_data", 64'(rsp_data), 64'h5775_5774);
    check("dr32_tap_rti", 64'(tap), 64'(RTI));

    // Response back-pressure for 20 cycles with a command offered
    base = tck_total;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_rsp_data", 64'(rsp_data), 64'h5775_5774);
      check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      check("hold_cmd_ready", 64'(cmd_ready), 64'd0);
    end
    check("hold_no_tck", 64'(tck_total - base), 64'd0);
    cmd_valid = 1'b0;
    finish_rsp();

    // SHIFT_DR, N=1
    base = tck_total;
    send(2'b10, 5'd0, 32'h0000_0001, 1'b0);
    wait_rsp(ptck);
    check("dr1_periods", 64'(tck_total - base), 64'd6);
    check("dr1_tms", 64'(tms_hist[5:0]), 64'b100110);
    check("dr1_tdi", 64'(tdi_hist[2]), 64'd1);
    check("dr1_rsp_data", 64'(rsp_data), 64'd0);
    finish_rsp();

    // Reserved opcode behaves as TAP_RESET with a zero response
    base = tck_total;
    send(2'b11, 5'd7, 32'h1234_5678, 1'b0);
    wait_rsp(ptck);
    check("trst_cmd_periods", 64'(tck_total - base), 64'd6);
    check("trst_cmd_tms", 64'(tms_hist[5:0]), 64'b111110);
    check("trst_cmd_rsp_data", 64'(rsp_data), 64'd0);
    check("trst_cmd_tap", 64'(tap), 64'(RTI));
    finish_rsp();

    // Abort an N=32 DR shift at shift bit 10
    base = tck_total;
    send(2'b10, 5'd31, 32'hFFFF_FFFF, 1'b0);
    begin
      int n;
      n = 0;
      while ((tck_total - base) < 13 && n < 2000) begin
        @(negedge clk);
        n++;
      end
      check("abort_reach_timeout", 64'(n < 2000), 64'd1);
    end
    check("abort_tap_shdr", 64'(tap), 64'(SHDR));
    rst = 1'b1;
    rbase = rsp_rises;
    @(negedge clk);
    check("abort_tck", 64'(tck), 64'd0);
    check("abort_tms", 64'(tms), 64'd1);
    check("abort_tdi", 64'(tdi), 64'd0);
    check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    check("abort_rsp_data", 64'(rsp_data), 64'd0);
    check("abort_cmd_ready", 64'(cmd_ready), 64'd0);
    repeat (2) @(negedge clk);
    base = tck_total;
    rst = 1'b0;
    wait_ready();
    check("abort_auto_periods", 64'(tck_total - base), 64'd6);
    check("abort_auto_tms", 64'(tms_hist[5:0]), 64'b111110);
    check("abort_tap_rti", 64'(tap), 64'(RTI));
    check("abort_no_rsp", 64'(rsp_rises - rbase), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
